// File: rtl/ramb_fifo_pkg.sv
// Shared constants and types for the RAMB-backed FIFO controller.
package ramb_fifo_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 4;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int AFULL_LVL = 4092;

    // Which side wins the single RAM port when both want it this cycle.
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

endpackage

// File: rtl/ramb_fifo_skid.sv
// Two-entry output buffer that absorbs the RAM read latency. Output is driven
// straight from the head register; push and pop may coincide at any occupancy.
// Handshake: a word leaves when out_valid & out_ready are both high on a rising
// edge; out_ready while out_valid is low has no effect.
module ramb_fifo_skid #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic [1:0]        occ_q;
    logic              pop;

    assign pop       = (occ_q != 2'd0) && out_ready;
    assign out_data  = head;
    assign out_valid = (occ_q != 2'd0);
    assign occ       = occ_q;

    // Occupancy and storage update for every push/pop combination.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head  <= push_data;
                        occ_q <= 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail  <= push_data;
                        occ_q <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ramb_s4_fifo_ctrl.sv
// FIFO controller using one external 4096x4 single-port block RAM as storage.
// The single RAM port is shared between writes and prefetch reads; a 2-entry
// buffer hides the one-cycle RAM read latency.
// Handshake: a word is transferred on IN (resp. OUT) at a rising edge where
// the corresponding VALID and READY are both high; READY never depends on VALID.
module ramb_s4_fifo_ctrl #(
    parameter int ADDR_W    = ramb_fifo_pkg::ADDR_W,
    parameter int DATA_W    = ramb_fifo_pkg::DATA_W,
    parameter int AFULL_LVL = ramb_fifo_pkg::AFULL_LVL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W+1:0] COUNT,
    output logic              FULL,
    output logic              AFULL,
    output logic              EMPTY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_SSR,
    input  logic [DATA_W-1:0] RAM_DO
);

    import ramb_fifo_pkg::*;

    localparam logic [ADDR_W:0] CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W+1)'(AFULL_LVL);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              inflight;
    logic [1:0]        buf_occ;
    prio_t             prio_q;
    prio_t             prio_d;
    logic              rd_req;
    logic              wr_req;
    logic              do_wr;
    logic              do_rd;

    // Prefetch only while the buffer plus the word in flight leaves room.
    assign rd_req   = (ram_cnt != '0) && (({1'b0, buf_occ} + {2'b00, inflight}) < 3'd2);
    assign wr_req   = IN_VALID && !FULL;
    assign IN_READY = !FULL && !(rd_req && (prio_q == PRIO_RD));
    assign do_wr    = IN_VALID && IN_READY;
    assign do_rd    = rd_req && !do_wr;

    assign RAM_EN   = do_wr || do_rd;
    assign RAM_WE   = do_wr;
    assign RAM_ADDR = do_wr ? wptr : rptr;
    assign RAM_DI   = IN_DATA;
    assign RAM_SSR  = RST;

    assign FULL  = (ram_cnt == CNT_FULL);
    assign AFULL = (ram_cnt >= CNT_AFULL);
    assign COUNT = {1'b0, ram_cnt} + (ADDR_W+2)'(inflight) + (ADDR_W+2)'(buf_occ);
    assign EMPTY = (COUNT == '0);

    // Arbitration priority register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prio_q <= PRIO_WR;
        end else begin
            prio_q <= prio_d;
        end
    end

    // After a contested cycle, hand priority to whichever side lost.
    always_comb begin
        prio_d = prio_q;
        if (rd_req && wr_req) begin
            prio_d = do_wr ? PRIO_RD : PRIO_WR;
        end
    end

    // Pointers, RAM occupancy and the read-in-flight marker.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= do_rd;
            if (do_wr) begin
                wptr    <= wptr + 1'b1;
                ram_cnt <= ram_cnt + 1'b1;
            end else if (do_rd) begin
                rptr    <= rptr + 1'b1;
                ram_cnt <= ram_cnt - 1'b1;
            end
        end
    end

    // RAM_DO is valid in the cycle after a read; it lands in the buffer then.
    ramb_fifo_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data (RAM_DO),
        .out_data  (OUT_DATA),
        .out_valid (OUT_VALID),
        .out_ready (OUT_READY),
        .occ       (buf_occ)
    );

endmodule

// File: tb/tb_ramb_s4_fifo_ctrl.sv
// Bench for ramb_s4_fifo_ctrl with a behavioural single-port RAM and a
// queue-based reference of the FIFO contents.
module tb_ramb_s4_fifo_ctrl;

    localparam int AW  = 12;
    localparam int DW  = 4;
    localparam int DEP = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] count;
    logic          full;
    logic          afull;
    logic          empty;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic          ram_en;
    logic          ram_we;
    logic          ram_ssr;
    logic [DW-1:0] ram_do;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;
    logic [DW-1:0] last_out;
    int            popped = 0;
    bit            lvl_en = 0;
    int            wcnt;
    int            p0;
    logic          prev_we;

    always #5 clk = ~clk;

    ramb_s4_fifo_ctrl dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .COUNT     (count),
        .FULL      (full),
        .AFULL     (afull),
        .EMPTY     (empty),
        .RAM_ADDR  (ram_addr),
        .RAM_DI    (ram_di),
        .RAM_EN    (ram_en),
        .RAM_WE    (ram_we),
        .RAM_SSR   (ram_ssr),
        .RAM_DO    (ram_do)
    );

    // Behavioural 4096x4 single-port RAM, synchronous read, SSR clears DO.
    logic [DW-1:0] mem [0:DEP-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            if (ram_ssr) ram_do <= '0;
            else if (!ram_we) ram_do <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pop/compare on every output transfer, push on accept.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_from_empty", 1, 0);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("out_data", out_data, exp_word);
                    last_out = out_data;
                    popped++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // Occupancy checks against the reference contents.
    always @(negedge clk) begin
        if (!rst && lvl_en) begin
            chk("count", count, exp_q.size());
            chk("empty", empty, exp_q.size() == 0);
            if (exp_q.size() == 0) chk("out_valid_when_empty", out_valid, 0);
        end
    end

    initial begin
        #(950000);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drain(input int expect_n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p0 = popped;
        for (int c = 0; c < 20000 && exp_q.size() != 0; c++) @(negedge clk);
        #1;
        chk("drain_words", popped - p0, expect_n);
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        #1 chk("ram_ssr_in_reset", ram_ssr, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ram_ssr", ram_ssr, 0);
        lvl_en = 1;

        // Single word latency.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA;
        #1;
        chk("t1_in_ready", in_ready, 1);
        chk("t1_ram_we", ram_we, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t1_lat1_valid", out_valid, 0);
        chk("t1_read_issued", ram_en && !ram_we, 1);
        chk("t1_read_addr", ram_addr, 0);
        @(negedge clk); #1;
        chk("t1_lat2_valid", out_valid, 0);
        @(negedge clk); #1;
        chk("t1_lat3_valid", out_valid, 1);
        chk("t1_lat3_data", out_data, 4'hA);
        chk("t1_count_before_pop", count, 1);
        @(negedge clk); #1;
        chk("t1_count_after_pop", count, 0);
        chk("t1_empty_after_pop", empty, 1);

        // Fill to FULL with no consumer.
        out_ready = 1'b0; in_valid = 1'b1; wcnt = 0;
        for (int c = 0; c < 6000 && !full; c++) begin
            in_data = DW'(wcnt % 16);
            #1;
            if (in_ready) wcnt++;
            if (c > 20) begin
                chk("fill_full", full, (exp_q.size() - 2) == DEP);
                chk("fill_afull", afull, (exp_q.size() - 2) >= 4092);
            end
            @(negedge clk);
        end
        #1;
        chk("full_flag", full, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_afull", afull, 1);
        chk("full_count", count, DEP + 2);
        chk("full_accepts", wcnt, DEP + 2);
        in_data = 4'hF;
        #1;
        chk("full_no_write", ram_we, 0);
        @(negedge clk); #1;
        chk("full_write_ignored", count, DEP + 2);
        drain(DEP + 2);

        // Saturated both sides: grants alternate.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (20) begin
            in_data = DW'($urandom_range(0, 15));
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (6) begin
            in_data = DW'($urandom_range(0, 15));
            @(negedge clk);
        end
        #1 prev_we = ram_we;
        repeat (30) begin
            @(negedge clk);
            in_data = DW'($urandom_range(0, 15));
            #1;
            chk("alt_ram_en", ram_en, 1);
            chk("alt_ram_we", ram_we, !prev_we);
            prev_we = ram_we;
        end
        drain(exp_q.size());

        // Random traffic with backpressure; pointers wrap again.
        wcnt = 0;
        for (int c = 0; c < 60000 && wcnt < 10000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = DW'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 1) != 0;
            #1;
            if (in_valid && in_ready) wcnt++;
        end
        @(negedge clk);
        chk("rand_accepts", wcnt, 10000);
        drain(exp_q.size());

        // Reset with contents held.
        out_ready = 1'b0; in_valid = 1'b1; wcnt = 0;
        for (int c = 0; c < 400 && wcnt < 100; c++) begin
            in_data = DW'($urandom_range(0, 15));
            #1;
            if (in_ready) wcnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_count", count, 100);
        chk("pre_rst_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid_rst_ssr", ram_ssr, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_full", full, 0);
        in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b1;
        p0 = popped;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10 && popped == p0; c++) @(negedge clk);
        chk("post_rst_popped", popped - p0, 1);
        chk("post_rst_first_word", last_out, 4'h5);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
